// File: rtl/dp_fifo_ctrl.sv
// rtl/dp_fifo_ctrl.sv - synchronous FIFO controller for an external dual-port RAM (1-cycle registered read)
// Optional feature macro: FIFO_ALMOST_FULL_EN adds a registered almost_full output.
module dp_fifo_ctrl #(
  parameter int mem_depth = 32,
  parameter int size      = 8,
  parameter int af_level  = 28
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [size-1:0]              data_in,
  output logic                         full,
  input  logic                         pop,
  output logic                         empty,
  output logic [size-1:0]              data_out,
  output logic                         out_valid,
  output logic [$clog2(mem_depth):0]   count,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         ram_wren,
  output logic [$clog2(mem_depth)-1:0] ram_wraddress,
  output logic [size-1:0]              ram_data_in,
  output logic                         ram_rden,
  output logic [$clog2(mem_depth)-1:0] ram_rdaddress,
  input  logic [size-1:0]              ram_data_out
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                         almost_full
`endif
);

  localparam int aw = $clog2(mem_depth);
  localparam logic [aw:0] depth_cnt = (aw+1)'(mem_depth);

  if (mem_depth < 4 || (mem_depth & (mem_depth - 1)) != 0) begin : g_depth_chk
    $error("mem_depth must be a power of two >= 4");
  end

  logic [aw-1:0] wptr;
  logic [aw-1:0] rptr;
  logic [aw:0]   count_nx;
  logic          wr_acc;
  logic          rd_acc;

  // Flags decode the registered count, so acceptance always sees pre-edge state.
  assign full  = (count == depth_cnt);
  assign empty = (count == '0);

  always_comb begin
    wr_acc   = push & ~full;
    rd_acc   = pop & ~empty;
    count_nx = count;
    if (wr_acc && !rd_acc) begin
      count_nx = count + (aw+1)'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nx = count - (aw+1)'(1);
    end
  end

  assign ram_wren      = wr_acc;
  assign ram_wraddress = wptr;
  assign ram_data_in   = data_in;
  assign ram_rden      = rd_acc;
  assign ram_rdaddress = rptr;
  assign data_out      = ram_data_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + aw'(1);
      end
      if (rd_acc) begin
        rptr <= rptr + aw'(1);
      end
      count     <= count_nx;
      out_valid <= rd_acc;
      if (push && full) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [aw:0] af_cnt = (aw+1)'(af_level);

  if (af_level == 0 || af_level > mem_depth) begin : g_af_chk
    $error("af_level must be in 1..mem_depth");
  end

  // Decoded from the next count so the registered flag tracks count exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nx >= af_cnt);
    end
  end
`else
  if (af_level < 0) begin : g_af_chk
    $error("af_level must be non-negative");
  end
`endif

endmodule

// File: tb/tb_dp_fifo_ctrl.sv
// tb/tb_dp_fifo_ctrl.sv - directed plus random checks of dp_fifo_ctrl against a queue model
module tb_dp_fifo_ctrl;

  localparam int DEPTH = 32;
  localparam int W     = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          push  = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          pop   = 1'b0;
  logic          full, empty, out_valid, overflow, underflow;
  logic [W-1:0]  data_out;
  logic [AW:0]   count;
  logic          ram_wren, ram_rden;
  logic [AW-1:0] ram_wraddress, ram_rdaddress;
  logic [W-1:0]  ram_data_in;
  logic [W-1:0]  ram_data_out = '0;
`ifdef FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  dp_fifo_ctrl #(.mem_depth(DEPTH), .size(W), .af_level(28)) dut (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .full         (full),
    .pop          (pop),
    .empty        (empty),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .ram_wren     (ram_wren),
    .ram_wraddress(ram_wraddress),
    .ram_data_in  (ram_data_in),
    .ram_rden     (ram_rden),
    .ram_rdaddress(ram_rdaddress),
    .ram_data_out (ram_data_out)
`ifdef FIFO_ALMOST_FULL_EN
    ,
    .almost_full  (almost_full)
`endif
  );

  always #5 clock = ~clock;

  // External RAM: registered read, no write-to-read bypass.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data_in;
    if (ram_rden) ram_data_out <= mem[ram_rdaddress];
  end

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  int           wr_total = 0;
  int           rd_total = 0;
  logic         exp_valid = 1'b0;
  logic [W-1:0] exp_data  = '0;
  logic         exp_ovf   = 1'b0;
  logic         exp_udf   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), mq.size());
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) chk("data_out", 32'(data_out), 32'(exp_data));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_udf));
  endtask

  task automatic model_reset();
    mq.delete();
    wr_total  = 0;
    rd_total  = 0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  task automatic step(input logic p, input logic [W-1:0] d, input logic q);
    logic wa, ra;
    @(negedge clock);
    check_state();
    push = p; data_in = d; pop = q;
    wa = p && (mq.size() < DEPTH);
    ra = q && (mq.size() != 0);
    #1;
    chk("ram_wren", 32'(ram_wren), 32'(wa));
    chk("ram_rden", 32'(ram_rden), 32'(ra));
    if (wa) begin
      chk("ram_wraddress", 32'(ram_wraddress), wr_total % DEPTH);
      chk("ram_data_in", 32'(ram_data_in), 32'(d));
    end
    if (ra) chk("ram_rdaddress", 32'(ram_rdaddress), rd_total % DEPTH);
    @(posedge clock);
    if (p && !wa) exp_ovf = 1'b1;
    if (q && !ra) exp_udf = 1'b1;
    exp_valid = ra;
    if (ra) begin
      exp_data = mq.pop_front();
      rd_total++;
    end
    if (wa) begin
      mq.push_back(d);
      wr_total++;
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #12;
    check_state();
    chk("reset_ram_wren", 32'(ram_wren), 0);
    chk("reset_ram_rden", 32'(ram_rden), 0);
    @(negedge clock);
    reset = 1'b0;

    // Three pushes then three pops.
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0);
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    step(0, 0, 0); step(0, 0, 0);

    // Fill to full, overflow on the extra push, then drain.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0);
    step(1, 8'hAA, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1);
    step(0, 0, 0);

    // Pointer wrap: fill, half drain, refill, drain.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1);
    step(0, 0, 0);

    // Push and pop together on an empty FIFO: pop rejected.
    step(1, 8'h5A, 1);
    step(0, 0, 1);
    step(0, 0, 0); step(0, 0, 0);

    // Streaming at count 10.
    for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0);
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    step(0, 0, 0);

    // Async reset mid-stream at count 7 with a read in flight.
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0);
    step(0, 0, 1);
    @(negedge clock);
    push = 1'b0; pop = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    @(negedge clock);
    reset = 1'b0;
    step(1, 8'h3C, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // Random traffic, push-biased then pop-biased.
    for (int i = 0; i < 200; i++) step(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0);
    for (int i = 0; i < 200; i++) step(($urandom % 4) == 0, 8'($urandom), ($urandom % 4) != 0);
    for (int i = 0; i < 200; i++) step($urandom % 2 == 1, 8'($urandom), $urandom % 2 == 1);
    step(0, 0, 0);
    @(negedge clock);
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
